fir_sample_driver: RTL

//  Streaming front/back end for lowpassfir_1. Buffers 8-bit samples from an upstream

---
 rtl/fir_sample_driver.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fir_sample_driver.sv
// Sample FIFO and handshake driver for the lowpassfir_1 filter interface.
// Optional done watchdog enabled by defining FIR_DRV_TIMEOUT_EN.
module fir_sample_driver #(
   parameter int DEPTH       = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  datain,
   output logic        datavalid,
   input  logic [7:0]  filtout,
   input  logic        done,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result_cnt,
   output logic        timeout_err
);

   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of 2 and >= 2");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_to
      $error("TIMEOUT_CYC out of range");
   end

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      OUT
   } state_t;

   state_t        state;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          done_q;
   logic          push;
   logic          pop;
   logic          done_rise;

   // in_ready depends only on the registered count, never on a same-cycle pop
   assign in_ready  = (count != (AW + 1)'(DEPTH));
   assign push      = in_valid & in_ready;
   assign pop       = (state == IDLE) && (count != '0);
   assign done_rise = done & ~done_q;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef FIR_DRV_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

   logic [15:0] to_cnt;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         done_q     <= 1'b0;
         datain     <= '0;
         datavalid  <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         result_cnt <= '0;
`ifdef FIR_DRV_TIMEOUT_EN
         to_cnt      <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         done_q <= done;
         unique case (state)
            IDLE: begin
               if (pop) begin
                  datain    <= mem[rd_ptr];
                  datavalid <= 1'b1;
                  state     <= WAIT;
`ifdef FIR_DRV_TIMEOUT_EN
                  to_cnt    <= '0;
`endif
               end
            end
            WAIT: begin
               if (done_rise) begin
                  out_data   <= filtout;
                  out_valid  <= 1'b1;
                  datavalid  <= 1'b0;
                  result_cnt <= result_cnt + 1'b1;
                  state      <= OUT;
`ifdef FIR_DRV_TIMEOUT_EN
               end else if (to_cnt == TO_LAST) begin
                  // a capture on the expiry cycle takes priority above
                  datavalid   <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
`endif
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef FIR_DRV_TIMEOUT_EN
   assign timeout_err = 1'b0;
`endif

endmodule
